sig_rom_arbiter: RTL and testbench

- Shares one sigmoid lookup ROM among NUM_REQ neurons of a layer.
- The ROM registers its address on clk and returns data combinationally from the registered address.
- Round-robin arbitration issues at most one lookup per cycle, fully pipelined.
- Each result is returned to its requester with a one-cycle ack pulse on a shared output bus.

---
 rtl/sig_rom_arbiter_if.sv | 41 ++++
 rtl/sig_rom_arbiter.sv | 129 ++++++++++++
 tb/tb_sig_rom_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sig_rom_arbiter_if.sv
// Bundle of request, result and ROM-side signals shared between the sigmoid
// ROM arbiter (slave side) and the layer of neurons plus the ROM (master side).
interface sig_rom_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int inWidth   = 10,
  parameter int dataWidth = 16,
  parameter int IDX_W     = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*inWidth-1:0] x_bus;
  logic [inWidth-1:0]         rom_x;
  logic [dataWidth-1:0]       rom_out;
  logic [NUM_REQ-1:0]         ack;
  logic [dataWidth-1:0]       out;
  logic [IDX_W-1:0]           out_idx;
  logic                       busy;

  modport slave (
    input  req,
    input  x_bus,
    input  rom_out,
    output rom_x,
    output ack,
    output out,
    output out_idx,
    output busy
  );

  modport master (
    output req,
    output x_bus,
    output rom_out,
    input  rom_x,
    input  ack,
    input  out,
    input  out_idx,
    input  busy
  );

endinterface

// File: rtl/sig_rom_arbiter.sv
// Round-robin arbiter sharing one registered-address sigmoid ROM among the
// neurons of a layer. One lookup issues per cycle; each result returns two
// edges after its grant as a one-cycle one-hot ack on the shared result bus.
module sig_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int inWidth   = 10,
  parameter int dataWidth = 16,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input logic              clk,
  input logic              rst_n,
  sig_rom_arbiter_if.slave bus
);

  localparam logic [NUM_REQ-1:0] LP_ONE = NUM_REQ'(1);

  logic [NUM_REQ-1:0]   w_eligible;
  logic                 w_grantValid;
  logic [IDX_W-1:0]     w_grantIdx;
  logic [inWidth-1:0]   w_grantX;
  logic [NUM_REQ-1:0]   w_setMask;
  int                   w_cand;

  logic [IDX_W-1:0]     r_rrPtr;
  logic [NUM_REQ-1:0]   r_inflight;
  logic [inWidth-1:0]   r_romX;
  logic                 r_s1Valid;
  logic [IDX_W-1:0]     r_s1Idx;
  logic                 r_s2Valid;
  logic [IDX_W-1:0]     r_s2Idx;
  logic [NUM_REQ-1:0]   r_ack;
  logic [dataWidth-1:0] r_out;
  logic [IDX_W-1:0]     r_outIdx;
  logic                 r_busy;

  // A requester whose lookup is still in the pipe cannot be granted again.
  assign w_eligible = bus.req & ~r_inflight;

  // Pick the first eligible requester starting at the round-robin pointer.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = int'(r_rrPtr) + k;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      if (!w_grantValid && w_eligible[IDX_W'(w_cand)]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = IDX_W'(w_cand);
      end
    end
  end

  // Select the granted requester's input and build its inflight set bit.
  always_comb begin
    w_grantX  = '0;
    w_setMask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grantIdx == IDX_W'(i)) begin
        w_grantX = bus.x_bus[i*inWidth +: inWidth];
      end
    end
    if (w_grantValid) begin
      w_setMask = LP_ONE << w_grantIdx;
    end
  end

  // Issue stage: drive the ROM address, advance the pointer, track inflight.
  // An ack clears its inflight bit and wins over a simultaneous set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_romX     <= '0;
      r_s1Valid  <= 1'b0;
      r_s1Idx    <= '0;
      r_rrPtr    <= '0;
      r_inflight <= '0;
    end else begin
      r_s1Valid  <= w_grantValid;
      r_inflight <= (r_inflight | w_setMask) & ~r_ack;
      if (w_grantValid) begin
        r_romX  <= w_grantX;
        r_s1Idx <= w_grantIdx;
        if (w_grantIdx == IDX_W'(NUM_REQ - 1)) begin
          r_rrPtr <= '0;
        end else begin
          r_rrPtr <= w_grantIdx + 1'b1;
        end
      end
    end
  end

  // Second stage tracks the lookup while the ROM registers its address;
  // busy is the registered "something is in stage 1 or stage 2" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Idx   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_s2Valid <= r_s1Valid;
      r_s2Idx   <= r_s1Idx;
      r_busy    <= w_grantValid | r_s1Valid;
    end
  end

  // Result stage: capture ROM data and pulse the ack of the owning requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= '0;
      r_outIdx <= '0;
      r_ack    <= '0;
    end else if (r_s2Valid) begin
      r_out    <= bus.rom_out;
      r_outIdx <= r_s2Idx;
      r_ack    <= LP_ONE << r_s2Idx;
    end else begin
      r_ack    <= '0;
    end
  end

  assign bus.rom_x   = r_romX;
  assign bus.ack     = r_ack;
  assign bus.out     = r_out;
  assign bus.out_idx = r_outIdx;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_sig_rom_arbiter.sv
// Self-checking bench for sig_rom_arbiter: table-driven single lookups,
// directed multi-cycle sequences and a randomized run, all compared against
// a lookup-queue reference model of the arbiter and a behavioural ROM.
module tb_sig_rom_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int IN_W      = 10;
  localparam int DATA_W    = 16;
  localparam int IDX_W     = 2;

  localparam int MODE_ONESHOT = 0;
  localparam int MODE_PERSIST = 1;
  localparam int MODE_RANDOM  = 2;

  typedef struct {
    int          visCycle;
    int          idx;
    logic [15:0] data;
  } lookup_t;

  typedef struct {
    int          idx;
    logic [9:0]  x;
    logic [15:0] expOut;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  reqDrv;
  logic [9:0]  xDrv [NUM_REQ];
  logic [3:0]  nextReq;
  logic [9:0]  nextX [NUM_REQ];
  logic [39:0] xBus;
  logic [9:0]  romAddr;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;
  int reqMode [NUM_REQ];
  int lastAckIdx;

  lookup_t     pipeQ[$];
  bit          mInflight [NUM_REQ];
  int          mPtr;
  logic [9:0]  mRomX;
  logic [15:0] mOut;
  int          mOutIdx;

  vec_t vecs [6];
  int   ackSeq[$];
  int   ackCycles[$];

  sig_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .inWidth(IN_W), .dataWidth(DATA_W), .IDX_W(IDX_W)) bus ();

  sig_rom_arbiter #(.NUM_REQ(NUM_REQ), .inWidth(IN_W), .dataWidth(DATA_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Pack the per-requester inputs onto the flat x bus.
  always_comb begin
    xBus = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      xBus[i*IN_W +: IN_W] = xDrv[i];
    end
  end

  assign bus.req   = reqDrv;
  assign bus.x_bus = xBus;

  // ROM stand-in: registered address, mem[a] = a, address = x ^ 10'h200.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) romAddr <= '0;
    else        romAddr <= bus.rom_x;
  end

  assign bus.rom_out = {6'b0, romAddr ^ 10'h200};

  function automatic logic [15:0] romModel(input logic [9:0] x);
    return {6'b0, x ^ 10'h200};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expVal);
    checks++;
    if (actual !== expVal) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expVal, cycleNo);
    end
  endtask

  task automatic resetModel();
    pipeQ.delete();
    for (int i = 0; i < NUM_REQ; i++) mInflight[i] = 1'b0;
    mPtr    = 0;
    mRomX   = '0;
    mOut    = '0;
    mOutIdx = 0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model over
  // the edge that ends the cycle.
  task automatic modelCycle();
    logic [3:0] expAck;
    logic       expBusy;
    int         ackIdx;
    int         g;
    int         c;
    lookup_t    e;
    expAck  = '0;
    expBusy = 1'b0;
    ackIdx  = -1;
    g       = -1;
    if (pipeQ.size() > 0 && pipeQ[0].visCycle == cycleNo) begin
      e       = pipeQ.pop_front();
      ackIdx  = e.idx;
      mOut    = e.data;
      mOutIdx = e.idx;
      expAck  = 4'(1 << e.idx);
    end
    foreach (pipeQ[j]) begin
      if (pipeQ[j].visCycle == cycleNo + 1 || pipeQ[j].visCycle == cycleNo + 2) expBusy = 1'b1;
    end
    checkOutput("model ack", 32'(bus.ack), 32'(expAck));
    checkOutput("model out", 32'(bus.out), 32'(mOut));
    checkOutput("model out_idx", 32'(bus.out_idx), 32'(mOutIdx));
    checkOutput("model busy", 32'(bus.busy), 32'(expBusy));
    checkOutput("model rom_x", 32'(bus.rom_x), 32'(mRomX));
    checkOutput("set/clear clash", 32'(dut.w_grantValid && bus.ack[dut.w_grantIdx]), 32'(0));
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (mPtr + k) % NUM_REQ;
      if (g < 0 && reqDrv[c] && !mInflight[c]) g = c;
    end
    if (g >= 0) begin
      mRomX        = xDrv[g];
      mInflight[g] = 1'b1;
      mPtr         = (g + 1) % NUM_REQ;
      e.visCycle   = cycleNo + 3;
      e.idx        = g;
      e.data       = romModel(xDrv[g]);
      pipeQ.push_back(e);
    end
    if (ackIdx >= 0) mInflight[ackIdx] = 1'b0;
    lastAckIdx = ackIdx;
  endtask

  // Decide each requester's inputs for the next cycle.
  task automatic planRequesters();
    nextReq = reqDrv;
    for (int i = 0; i < NUM_REQ; i++) begin
      nextX[i] = xDrv[i];
      case (reqMode[i])
        MODE_ONESHOT: if (lastAckIdx == i) nextReq[i] = 1'b0;
        MODE_PERSIST: if (lastAckIdx == i) nextX[i] = xDrv[i] + 10'd37;
        default: begin
          if (lastAckIdx == i) begin
            if ($urandom_range(1, 0) == 1) nextX[i] = 10'($urandom);
            else nextReq[i] = 1'b0;
          end else if (!reqDrv[i] && $urandom_range(3, 0) == 0) begin
            nextReq[i] = 1'b1;
            nextX[i]   = 10'($urandom);
          end
        end
      endcase
    end
  endtask

  task automatic applyStimulus();
    reqDrv = nextReq;
    for (int i = 0; i < NUM_REQ; i++) xDrv[i] = nextX[i];
  endtask

  task automatic stepCycle();
    @(negedge clk);
    modelCycle();
    planRequesters();
    @(posedge clk);
    #1;
    applyStimulus();
    cycleNo++;
  endtask

  task automatic doReset();
    rst_n  = 1'b0;
    reqDrv = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      xDrv[i]    = '0;
      reqMode[i] = MODE_ONESHOT;
    end
    @(posedge clk);
    #1;
    checkOutput("reset rom_x", 32'(bus.rom_x), 32'(0));
    checkOutput("reset ack", 32'(bus.ack), 32'(0));
    checkOutput("reset out", 32'(bus.out), 32'(0));
    checkOutput("reset out_idx", 32'(bus.out_idx), 32'(0));
    checkOutput("reset busy", 32'(bus.busy), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resetModel();
    cycleNo = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < NUM_REQ; i++) reqMode[i] = MODE_ONESHOT;
    for (int s = 0; s < n; s++) stepCycle();
  endtask

  initial begin
    vecs[0] = '{idx: 1, x: 10'h005, expOut: 16'h0205};
    vecs[1] = '{idx: 0, x: 10'h3FF, expOut: 16'h01FF};
    vecs[2] = '{idx: 2, x: 10'h000, expOut: 16'h0200};
    vecs[3] = '{idx: 3, x: 10'h200, expOut: 16'h0000};
    vecs[4] = '{idx: 1, x: 10'h1FF, expOut: 16'h03FF};
    vecs[5] = '{idx: 3, x: 10'h2AB, expOut: 16'h00AB};

    doReset();

    $display("[TB] single-lookup table");
    for (int v = 0; v < 6; v++) begin
      reqDrv             = 4'(1 << vecs[v].idx);
      xDrv[vecs[v].idx]  = vecs[v].x;
      stepCycle();
      checkOutput($sformatf("vec%0d rom_x", v), 32'(bus.rom_x), 32'(vecs[v].x));
      checkOutput($sformatf("vec%0d busy c1", v), 32'(bus.busy), 32'(1));
      stepCycle();
      checkOutput($sformatf("vec%0d busy c2", v), 32'(bus.busy), 32'(1));
      checkOutput($sformatf("vec%0d early ack", v), 32'(bus.ack), 32'(0));
      stepCycle();
      checkOutput($sformatf("vec%0d ack", v), 32'(bus.ack), 32'(1 << vecs[v].idx));
      checkOutput($sformatf("vec%0d out", v), 32'(bus.out), 32'(vecs[v].expOut));
      checkOutput($sformatf("vec%0d out_idx", v), 32'(bus.out_idx), 32'(vecs[v].idx));
      checkOutput($sformatf("vec%0d busy c3", v), 32'(bus.busy), 32'(0));
      stepCycle();
      checkOutput($sformatf("vec%0d ack drop", v), 32'(bus.ack), 32'(0));
      checkOutput($sformatf("vec%0d out hold", v), 32'(bus.out), 32'(vecs[v].expOut));
    end

    $display("[TB] all four requesters");
    doReset();
    reqDrv = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) xDrv[i] = 10'(i + 1);
    for (int s = 1; s <= 7; s++) begin
      stepCycle();
      if (s <= 4) checkOutput($sformatf("all4 rom_x s%0d", s), 32'(bus.rom_x), 32'(s));
      if (s >= 3 && s <= 6) begin
        checkOutput($sformatf("all4 ack s%0d", s), 32'(bus.ack), 32'(1 << (s - 3)));
        checkOutput($sformatf("all4 out s%0d", s), 32'(bus.out), 32'(16'h0201 + 16'(s - 3)));
        checkOutput($sformatf("all4 out_idx s%0d", s), 32'(bus.out_idx), 32'(s - 3));
      end
    end
    checkOutput("all4 ack after", 32'(bus.ack), 32'(0));

    $display("[TB] fairness 0/2");
    doReset();
    reqMode[0] = MODE_PERSIST;
    reqMode[2] = MODE_PERSIST;
    reqDrv     = 4'b0101;
    xDrv[0]    = 10'h010;
    xDrv[2]    = 10'h020;
    ackSeq.delete();
    for (int s = 0; s < 200 && ackSeq.size() < 20; s++) begin
      stepCycle();
      if (bus.ack != 4'b0000) ackSeq.push_back(int'(bus.out_idx));
    end
    checkOutput("fair ack count", 32'(ackSeq.size()), 32'(20));
    foreach (ackSeq[j]) begin
      checkOutput($sformatf("fair order %0d", j), 32'(ackSeq[j]), 32'((j % 2 == 0) ? 0 : 2));
    end
    drain(10);

    $display("[TB] back-to-back requester 3");
    doReset();
    reqMode[3] = MODE_PERSIST;
    reqDrv     = 4'b1000;
    xDrv[3]    = 10'h100;
    ackCycles.delete();
    for (int s = 0; s < 40 && ackCycles.size() < 5; s++) begin
      stepCycle();
      if (bus.ack[3]) ackCycles.push_back(cycleNo);
    end
    checkOutput("b2b ack count", 32'(ackCycles.size()), 32'(5));
    if (ackCycles.size() > 0) checkOutput("b2b first ack", 32'(ackCycles[0]), 32'(3));
    for (int j = 1; j < ackCycles.size(); j++) begin
      checkOutput($sformatf("b2b gap %0d", j), 32'(ackCycles[j] - ackCycles[j-1]), 32'(4));
    end
    drain(10);

    $display("[TB] reset mid-flight");
    doReset();
    reqDrv  = 4'b0010;
    xDrv[1] = 10'h0AA;
    stepCycle();
    checkOutput("midrst granted", 32'(bus.rom_x), 32'(10'h0AA));
    rst_n = 1'b0;
    #1;
    checkOutput("midrst ack", 32'(bus.ack), 32'(0));
    checkOutput("midrst busy", 32'(bus.busy), 32'(0));
    checkOutput("midrst rom_x", 32'(bus.rom_x), 32'(0));
    #1;
    rst_n = 1'b1;
    resetModel();
    cycleNo = 0;
    stepCycle();
    checkOutput("midrst regrant", 32'(bus.rom_x), 32'(10'h0AA));
    checkOutput("midrst busy after", 32'(bus.busy), 32'(1));
    stepCycle();
    checkOutput("midrst no early ack", 32'(bus.ack), 32'(0));
    stepCycle();
    checkOutput("midrst ack", 32'(bus.ack), 32'(4'b0010));
    checkOutput("midrst out", 32'(bus.out), 32'(16'h02AA));
    drain(6);

    $display("[TB] randomized run");
    doReset();
    for (int i = 0; i < NUM_REQ; i++) reqMode[i] = MODE_RANDOM;
    for (int s = 0; s < 1500; s++) stepCycle();
    drain(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
